// File: rtl/alu_ctrl_pkg.sv
// Shared types, operation codes and operator encode/decode helpers for the
// ALU operator sequencer.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HOLD,
        AUTO
    } state_t;

    localparam logic [2:0] OP_DISP   = 3'd0;
    localparam logic [2:0] OP_BIN    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_MUL    = 3'd3;
    localparam logic [2:0] OP_CNT    = 3'd4;
    localparam logic [2:0] OP_SHIFT  = 3'd5;
    localparam logic [2:0] OP_MEDIAN = 3'd6;

    // Keep only the highest-priority button: bit0 > bit1 > bit2 > bit5 > bit4 > bit3.
    function automatic logic [5:0] prio_onehot(input logic [5:0] b);
        prio_onehot = 6'b000000;
        if (b[0])      prio_onehot = 6'b000001;
        else if (b[1]) prio_onehot = 6'b000010;
        else if (b[2]) prio_onehot = 6'b000100;
        else if (b[5]) prio_onehot = 6'b100000;
        else if (b[4]) prio_onehot = 6'b010000;
        else if (b[3]) prio_onehot = 6'b001000;
    endfunction

    // Code 0 is plain display (no operator bit); code k selects bit k-1.
    function automatic logic [5:0] code_to_onehot(input logic [2:0] code);
        case (code)
            OP_BIN:    code_to_onehot = 6'b000001;
            OP_ADD:    code_to_onehot = 6'b000010;
            OP_MUL:    code_to_onehot = 6'b000100;
            OP_CNT:    code_to_onehot = 6'b001000;
            OP_SHIFT:  code_to_onehot = 6'b010000;
            OP_MEDIAN: code_to_onehot = 6'b100000;
            default:   code_to_onehot = 6'b000000;
        endcase
    endfunction

    // Inverse of code_to_onehot; anything not one-hot maps to plain display.
    function automatic logic [2:0] onehot_to_code(input logic [5:0] oh);
        case (oh)
            6'b000001: onehot_to_code = OP_BIN;
            6'b000010: onehot_to_code = OP_ADD;
            6'b000100: onehot_to_code = OP_MUL;
            6'b001000: onehot_to_code = OP_CNT;
            6'b010000: onehot_to_code = OP_SHIFT;
            6'b100000: onehot_to_code = OP_MEDIAN;
            default:   onehot_to_code = OP_DISP;
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; both clear on reset so no stale press survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Button debounce / operator latch / auto-scan front-end for the ALU display
// datapath. Outputs are registered and change only at update instants.
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DWELL_CYCLES    = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] operand_in,
    input  logic [5:0] btn,
    input  logic       auto_en,
    output logic [9:0] operand_out,
    output logic [5:0] operator_out,
    output logic [2:0] op_code,
    output logic       op_valid,
    output logic       auto_active
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > DWELL_CYCLES) ? DEBOUNCE_CYCLES : DWELL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [5:0]       btn_s;
    logic             auto_s;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [5:0]       cand, cand_nx;
    logic [9:0]       operand_nx;
    logic [5:0]       operator_nx;
    logic [2:0]       code_nx;
    logic             valid_nx;
    logic [5:0]       win;
    logic [2:0]       adv_code;

    sync_2ff #(.WIDTH(7)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({auto_en, btn}),
        .q   ({auto_s, btn_s})
    );

    assign win         = prio_onehot(btn_s);
    assign adv_code    = (op_code == OP_MEDIAN) ? OP_DISP : op_code + 3'd1;
    assign auto_active = (state == AUTO);

    // State, shared counter and latched outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            cand         <= '0;
            operand_out  <= '0;
            operator_out <= '0;
            op_code      <= OP_DISP;
            op_valid     <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            cand         <= cand_nx;
            operand_out  <= operand_nx;
            operator_out <= operator_nx;
            op_code      <= code_nx;
            op_valid     <= valid_nx;
        end
    end

    // Next state, counter and output updates; outputs hold unless updated.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        cand_nx     = cand;
        operand_nx  = operand_out;
        operator_nx = operator_out;
        code_nx     = op_code;
        valid_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (|btn_s) begin
                    // A button beats auto-scan when both are present.
                    state_nx = DEBOUNCE;
                    cand_nx  = win;
                    cnt_nx   = '0;
                end else if (auto_s) begin
                    // Entering auto steps immediately so the user sees a change.
                    state_nx    = AUTO;
                    cnt_nx      = '0;
                    code_nx     = adv_code;
                    operator_nx = code_to_onehot(adv_code);
                    operand_nx  = operand_in;
                    valid_nx    = 1'b1;
                end
            end
            DEBOUNCE: begin
                // Only the original candidate matters; later buttons are ignored.
                if (|(btn_s & cand)) begin
                    if (cnt == DEB_LAST) begin
                        operator_nx = cand;
                        code_nx     = onehot_to_code(cand);
                        operand_nx  = operand_in;
                        valid_nx    = 1'b1;
                        state_nx    = HOLD;
                        cnt_nx      = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            HOLD: begin
                // Require a debounced release before another press is taken.
                if (|btn_s) begin
                    cnt_nx = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            AUTO: begin
                if (|btn_s) begin
                    state_nx = DEBOUNCE;
                    cand_nx  = win;
                    cnt_nx   = '0;
                end else if (!auto_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == DWELL_LAST) begin
                    cnt_nx      = '0;
                    code_nx     = adv_code;
                    operator_nx = code_to_onehot(adv_code);
                    operand_nx  = operand_in;
                    valid_nx    = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with DEBOUNCE_CYCLES=4, DWELL_CYCLES=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst;
    logic [9:0] operand_in;
    logic [5:0] btn;
    logic       auto_en;
    logic [9:0] operand_out;
    logic [5:0] operator_out;
    logic [2:0] op_code;
    logic       op_valid;
    logic       auto_active;

    int n_total = 0;
    int n_pass  = 0;

    alu_op_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .DWELL_CYCLES    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .operand_in   (operand_in),
        .btn          (btn),
        .auto_en      (auto_en),
        .operand_out  (operand_out),
        .operator_out (operator_out),
        .op_code      (op_code),
        .op_valid     (op_valid),
        .auto_active  (auto_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until op_valid is seen; n = steps taken, or -1 if the budget ran out.
    task automatic wait_valid(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (op_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int cycles, output int c);
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (op_valid === 1'b1) c++;
        end
    endtask

    function automatic logic [5:0] exp_onehot(input int code);
        logic [5:0] one;
        one = 6'b000001;
        exp_onehot = (code == 0) ? 6'b000000 : (one << (code - 1));
    endfunction

    int n;
    int c;

    initial begin
        rst        = 1'b1;
        operand_in = 10'h2A3;
        btn        = 6'b000001;
        auto_en    = 1'b0;

        // 1: reset held with a button pressed
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_valid", op_valid, 0);
            chk("rst_operator", operator_out, 0);
        end
        chk("rst_code", op_code, 0);
        chk("rst_operand", operand_out, 0);
        chk("rst_auto", auto_active, 0);
        rst = 1'b0;
        wait_valid(12, n);
        chk("rst_release_latency", n, 7);
        chk("t1_operator", operator_out, 6'b000001);
        chk("t1_code", op_code, 1);
        chk("t1_operand", operand_out, 10'h2A3);
        step();
        chk("t1_pulse_width", op_valid, 0);
        btn = 6'b000000;
        repeat (8) step();

        // 2: clean press of bit2 with a fresh operand
        operand_in = 10'h155;
        btn        = 6'b000100;
        n = 0;
        c = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (op_valid === 1'b1) c++;
        end
        chk("t2_pulses", c, 1);
        chk("t2_operator", operator_out, 6'b000100);
        chk("t2_code", op_code, 3);
        chk("t2_operand", operand_out, 10'h155);
        operand_in = 10'h0AA;
        btn        = 6'b000000;
        repeat (8) step();
        chk("t2_operand_latched", operand_out, 10'h155);

        // 3: two-cycle bounce is rejected
        btn = 6'b000010;
        repeat (2) step();
        btn = 6'b000000;
        count_pulses(8, c);
        chk("t3_pulses", c, 0);
        chk("t3_operator", operator_out, 6'b000100);
        chk("t3_code", op_code, 3);

        // 4: bit5 beats bit3; quick re-press stays in HOLD
        btn = 6'b101000;
        wait_valid(12, n);
        chk("t4_latency", n, 7);
        chk("t4_operator", operator_out, 6'b100000);
        chk("t4_code", op_code, 6);
        chk("t4_operand", operand_out, 10'h0AA);
        btn = 6'b000000;
        repeat (2) step();
        btn = 6'b101000;
        count_pulses(8, c);
        chk("t4_repress_pulses", c, 0);
        btn = 6'b000000;
        count_pulses(8, c);
        chk("t4_release_pulses", c, 0);
        chk("t4_operator_sticky", operator_out, 6'b100000);

        // Reset in the middle of a debounce gives no pulse
        btn = 6'b000010;
        repeat (5) step();
        rst = 1'b1;
        btn = 6'b000000;
        step();
        chk("midrst_valid", op_valid, 0);
        chk("midrst_code", op_code, 0);
        chk("midrst_operator", operator_out, 0);
        step();
        rst = 1'b0;
        count_pulses(6, c);
        chk("midrst_pulses", c, 0);

        // 5: auto-scan from code 0
        operand_in = 10'h3C1;
        auto_en    = 1'b1;
        wait_valid(6, n);
        chk("t5_entry_latency", n, 3);
        chk("t5_entry_code", op_code, 1);
        chk("t5_entry_operand", operand_out, 10'h3C1);
        chk("t5_auto_active", auto_active, 1);
        for (int k = 2; k <= 7; k++) begin
            wait_valid(12, n);
            chk("t5_spacing", n, 8);
            chk("t5_code", op_code, k % 7);
            chk("t5_operator", operator_out, exp_onehot(k % 7));
            chk("t5_active", auto_active, 1);
        end

        // 6: button pre-empts auto at code 4
        for (int k = 1; k <= 4; k++) begin
            wait_valid(12, n);
            chk("t6_spacing", n, 8);
            chk("t6_code", op_code, k);
        end
        btn = 6'b000001;
        repeat (3) step();
        chk("t6_auto_dropped", auto_active, 0);
        chk("t6_code_held", op_code, 4);
        wait_valid(8, n);
        chk("t6_debounce_latency", n, 4);
        chk("t6_code", op_code, 1);
        chk("t6_operator", operator_out, 6'b000001);
        btn     = 6'b000000;
        auto_en = 1'b0;
        count_pulses(12, c);
        chk("t6_idle_pulses", c, 0);
        chk("t6_code_retained", op_code, 1);
        chk("t6_auto_off", auto_active, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
